spi_sub: RTL and testbench

Subordinate SPI receiver that deserializes frames in the same format `spi_main` transmits: 2 power-state bits followed by a WORD_WIDTH-bit data word, MSB first, framed by an active-low chip select. It oversamples the external SPI pins in the `sys_clk` domain and presents each complete frame on a parallel port with a valid/ack handshake. It sits between an off-chip controller and the synthesizer's control registers.

---
 rtl/spi_sub.sv | 205 ++++++++++++++++++++
 tb/tb_spi_sub.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sub.sv
// spi_sub: SPI subordinate receiver. Oversamples sclk/mosi/csb in the sys_clk
// domain, deserializes {power_state[1:0], data[WORD_WIDTH-1:0]} MSB first and
// presents each accepted frame on a valid/ack parallel port.
// Optional feature macro: SPI_SUB_FRAME_ERR_EN enables frame-length checking
// and the frame_err pulse; without it any frame with at least one bit is
// accepted using the last SR_WIDTH bits shifted in.
//
// state   | meaning
// S_IDLE  | waiting for an armed csb falling edge
// S_SHIFT | frame in progress, shifting on sclk falling edges
// S_CHECK | one cycle: decide accept/reject of the completed frame
module spi_sub #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  csb,
  input  logic                  out_ack,
  output logic [WORD_WIDTH-1:0] parallel_out,
  output logic [1:0]            power_state,
  output logic                  out_valid,
  output logic                  overrun,
  output logic                  frame_err
);
  localparam int SR_WIDTH = WORD_WIDTH + 2;
  localparam int CNT_W    = $clog2(SR_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]          r_sclk_s;
  logic [2:0]          r_csb_s;
  logic [1:0]          r_mosi_s;
  logic [1:0]          r_sync_vld;
  logic                r_armed;
  logic                w_sclk_fall;
  logic                w_csb_fall;
  logic                w_csb_rise;
  logic                w_mosi_s;
  logic                w_start;
  logic                w_shift;
  logic                w_check;
  logic                w_shift_allow;
  logic                w_frame_ok;
  logic [SR_WIDTH-1:0] r_shift;
  logic [SR_WIDTH-1:0] r_frame;
  logic                r_acc;
  logic                r_rej;

  // Two synchronizer stages plus one delay stage for edge detection; mosi
  // stops at stage two so it lines up with the sclk edge compare.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s   <= 3'b000;
      r_csb_s    <= 3'b111;
      r_mosi_s   <= 2'b00;
      r_sync_vld <= 2'b00;
    end else begin
      r_sclk_s   <= {r_sclk_s[1:0], sclk};
      r_csb_s    <= {r_csb_s[1:0], csb};
      r_mosi_s   <= {r_mosi_s[0], mosi};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // csb must be seen high (a real pin sample, not the reset value) before a
  // falling edge may start a frame, so a csb held low through reset is ignored.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      r_armed <= 1'b0;
    else if (r_sync_vld[1] && r_csb_s[1])
      r_armed <= 1'b1;
  end

  assign w_sclk_fall = r_sclk_s[2] & ~r_sclk_s[1];
  assign w_csb_fall  = r_armed & r_csb_s[2] & ~r_csb_s[1];
  assign w_csb_rise  = ~r_csb_s[2] & r_csb_s[1];
  assign w_mosi_s    = r_mosi_s[1];

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_check     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_csb_fall) begin
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_csb_rise)
          w_state_nxt = S_CHECK;
        else if (w_sclk_fall && w_shift_allow)
          w_shift = 1'b1;
      end
      S_CHECK: begin
        w_check     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SPI_SUB_FRAME_ERR_EN
  localparam bit FRAME_ERR_EN = 1'b1;
  logic [CNT_W-1:0] r_cnt;

  // Shifting stops once the count passes SR_WIDTH, so the counter saturates
  // at SR_WIDTH+1 and a long frame can never alias to a legal length.
  assign w_shift_allow = (r_cnt <= CNT_W'(SR_WIDTH));
  assign w_frame_ok    = (r_cnt == CNT_W'(SR_WIDTH));

  // Bit counter for the current frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_start)
      r_cnt <= '0;
    else if (w_shift)
      r_cnt <= r_cnt + 1'b1;
  end
`else
  localparam bit FRAME_ERR_EN = 1'b0;
  logic r_seen;

  assign w_shift_allow = 1'b1;
  assign w_frame_ok    = r_seen;

  // Only whether any bit arrived matters when length is not checked.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      r_seen <= 1'b0;
    else if (w_start)
      r_seen <= 1'b0;
    else if (w_shift)
      r_seen <= 1'b1;
  end
`endif

  // Shift register, cleared at frame start so short frames are zero-padded.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      r_shift <= '0;
    else if (w_start)
      r_shift <= '0;
    else if (w_shift)
      r_shift <= {r_shift[SR_WIDTH-2:0], w_mosi_s};
  end

  // Registered accept/reject decision; the frame is captured so a quick new
  // csb falling edge cannot clear it before the output update.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= 1'b0;
      r_rej   <= 1'b0;
      r_frame <= '0;
    end else begin
      r_acc <= w_check & w_frame_ok;
      r_rej <= w_check & ~w_frame_ok;
      if (w_check)
        r_frame <= r_shift;
    end
  end

  // Output port and valid/ack handshake; a new frame wins over an ack.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      parallel_out <= '0;
      power_state  <= 2'b00;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= FRAME_ERR_EN & r_rej;
      if (r_acc) begin
        {power_state, parallel_out} <= r_frame;
        out_valid                   <= 1'b1;
        overrun                     <= out_valid & ~out_ack;
      end else if (out_valid && out_ack) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sub.sv
// Testbench for spi_sub: table of frames plus hand-written sequences for
// ack/accept collision, latency, and reset in the middle of a frame.
module tb_spi_sub;
  localparam int WW = 16;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          sclk    = 1'b0;
  logic          mosi    = 1'b0;
  logic          csb     = 1'b1;
  logic          out_ack = 1'b0;
  logic [WW-1:0] parallel_out;
  logic [1:0]    power_state;
  logic          out_valid;
  logic          overrun;
  logic          frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  always #5 sys_clk = ~sys_clk;

  spi_sub #(.WORD_WIDTH(WW)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .mosi         (mosi),
    .csb          (csb),
    .out_ack      (out_ack),
    .parallel_out (parallel_out),
    .power_state  (power_state),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  typedef struct {
    bit         rej;
    logic [1:0] pwr;
    logic [15:0] data;
    bit         ovr;
  } exp_t;

  typedef struct {
    logic [18:0] val;
    int          nbits;
    bit          evt;
    bit          rej;
    logic [1:0]  pwr;
    logic [15:0] data;
    bit          ovr;
    bit          ack;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input bit rej, input logic [1:0] pwr, input logic [15:0] data,
                          input bit ovr);
    exp_t x;
    x.rej  = rej;
    x.pwr  = pwr;
    x.data = data;
    x.ovr  = ovr;
    sb.push_back(x);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Called on a negedge: csb low, then nbits of val MSB first; csb left low.
  task automatic send_bits(input logic [18:0] val, input int nbits);
    csb = 1'b0;
    wait_n(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = val[i];
      sclk = 1'b1;
      wait_n(4);
      sclk = 1'b0;
      wait_n(4);
    end
  endtask

  task automatic raise_csb();
    csb = 1'b1;
    wait_n(12);
  endtask

  task automatic do_ack(input string name);
    check({name, "_valid_before_ack"}, 32'(out_valid), 32'd1);
    out_ack = 1'b1;
    wait_n(1);
    out_ack = 1'b0;
    check({name, "_valid_after_ack"}, 32'(out_valid), 32'd0);
  endtask

  // Monitor: every output event pops one expected record.
  initial begin
    logic [17:0] prev_out;
    logic        prev_valid;
    exp_t        e;
    prev_out   = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (mon_en && (frame_err || overrun || (out_valid && !prev_valid) ||
                     ({power_state, parallel_out} != prev_out))) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got out=%h valid=%b ovr=%b err=%b, want no event",
                   {power_state, parallel_out}, out_valid, overrun, frame_err);
        end else begin
          e = sb.pop_front();
          check("frame_err", 32'(frame_err), 32'(e.rej));
          check("power_state", 32'(power_state), 32'(e.pwr));
          check("parallel_out", 32'(parallel_out), 32'(e.data));
          check("overrun", 32'(overrun), 32'(e.ovr));
          if (!e.rej) check("out_valid_on_accept", 32'(out_valid), 32'd1);
        end
      end
      prev_out   = {power_state, parallel_out};
      prev_valid = out_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    //          val         nbits evt rej pwr    data      ovr ack
    vt[0] = '{19'h1A5C3, 18, 1'b1, 1'b0, 2'b01, 16'hA5C3, 1'b0, 1'b1};
    vt[1] = '{19'h21234, 18, 1'b1, 1'b0, 2'b10, 16'h1234, 1'b0, 1'b0};
    vt[2] = '{19'h35678, 18, 1'b1, 1'b0, 2'b11, 16'h5678, 1'b1, 1'b1};
`ifdef SPI_SUB_FRAME_ERR_EN
    vt[3] = '{19'h1F00F, 17, 1'b1, 1'b1, 2'b11, 16'h5678, 1'b0, 1'b0};
    vt[4] = '{19'h4C3A5, 19, 1'b1, 1'b1, 2'b11, 16'h5678, 1'b0, 1'b0};
    vt[5] = '{19'h00000,  0, 1'b1, 1'b1, 2'b11, 16'h5678, 1'b0, 1'b0};
`else
    vt[3] = '{19'h1F00F, 17, 1'b1, 1'b0, 2'b01, 16'hF00F, 1'b0, 1'b1};
    vt[4] = '{19'h4C3A5, 19, 1'b1, 1'b0, 2'b00, 16'hC3A5, 1'b0, 1'b1};
    vt[5] = '{19'h00000,  0, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0};
`endif
    vt[6] = '{19'h20F0F, 18, 1'b1, 1'b0, 2'b10, 16'h0F0F, 1'b0, 1'b1};

    // Reset state.
    wait_n(3);
    check("rst_parallel_out", 32'(parallel_out), 32'd0);
    check("rst_power_state", 32'(power_state), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    wait_n(5);
    mon_en = 1'b1;

    // Table of frames.
    for (int k = 0; k < 7; k++) begin
      send_bits(vt[k].val, vt[k].nbits);
      if (vt[k].evt) push_exp(vt[k].rej, vt[k].pwr, vt[k].data, vt[k].ovr);
      raise_csb();
      check($sformatf("row%0d_event_seen", k), 32'(sb.size()), 32'd0);
      if (vt[k].ack) do_ack($sformatf("row%0d", k));
    end

    // Ack arriving in the same cycle a new frame is accepted.
    send_bits(19'h11111, 18);
    push_exp(1'b0, 2'b01, 16'h1111, 1'b0);
    raise_csb();
    send_bits(19'h22222, 18);
    push_exp(1'b0, 2'b10, 16'h2222, 1'b0);
    csb = 1'b1;
    wait_n(4);
    out_ack = 1'b1;
    wait_n(1);
    out_ack = 1'b0;
    wait_n(2);
    check("collision_valid_held", 32'(out_valid), 32'd1);
    check("collision_event_seen", 32'(sb.size()), 32'd0);
    wait_n(8);
    do_ack("collision");

    // csb pin rise to out_valid latency.
    send_bits(19'h38001, 18);
    push_exp(1'b0, 2'b11, 16'h8001, 1'b0);
    csb = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge sys_clk);
      #1;
      cyc++;
    end
    check("csb_to_valid_cycles", 32'(cyc), 32'd5);
    @(negedge sys_clk);
    wait_n(10);
    check("latency_event_seen", 32'(sb.size()), 32'd0);

    // Reset after 9 bits, leaving the previous frame unacknowledged.
    send_bits(19'h3DEAD, 9);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    wait_n(1);
    check("midrst_parallel_out", 32'(parallel_out), 32'd0);
    check("midrst_power_state", 32'(power_state), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(4);
    mon_en = 1'b1;
    send_bits(19'h2BEEF, 18);
    wait_n(6);
    csb = 1'b1;
    wait_n(12);
    check("no_accept_without_fresh_csb", 32'(out_valid), 32'd0);
    send_bits(19'h2BEEF, 18);
    push_exp(1'b0, 2'b10, 16'hBEEF, 1'b0);
    raise_csb();
    check("beef_event_seen", 32'(sb.size()), 32'd0);
    do_ack("beef");

    wait_n(10);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
